// File: rtl/fpro_nios2_gen2_0_cpu_debug_mon_master.sv
// Debug monitor master: turns debug-slave OCI memory command strobes into single-word
// Avalon-MM reads/writes and reports read data, ready and error back to the TCK side.
module fpro_nios2_gen2_0_cpu_debug_mon_master #(
  parameter int ADDR_W  = 24,
  parameter int TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [37:0]         jdo,
  input  logic                take_action_ocimem_a,
  input  logic                take_no_action_ocimem_a,
  input  logic                take_action_ocimem_b,
  output logic [31:0]         MonDReg,
  output logic                monitor_ready,
  output logic                monitor_error,
  output logic [ADDR_W+1:0]   avm_address,
  output logic                avm_read,
  output logic                avm_write,
  output logic [31:0]         avm_writedata,
  output logic [3:0]          avm_byteenable,
  input  logic [31:0]         avm_readdata,
  input  logic                avm_waitrequest
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_t;

  state_t              state_r;
  logic [ADDR_W-1:0]   addr_r;
  logic                inc_en_r;
  logic [TW-1:0]       tmo_cnt_r;
  logic                any_strobe_s;
  logic                unused_jdo_s;

  assign any_strobe_s   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign avm_address    = {addr_r, 2'b00};
  assign avm_byteenable = 4'hF;
  assign unused_jdo_s   = ^{jdo[37:36], jdo[1:0]};

  // Command decode, Avalon access sequencing and status reporting
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      addr_r        <= '0;
      inc_en_r      <= 1'b0;
      tmo_cnt_r     <= '0;
      MonDReg       <= 32'h0000_0000;
      monitor_ready <= 1'b1;
      monitor_error <= 1'b0;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_writedata <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          tmo_cnt_r <= '0;
          // Priority ocimem_a > ocimem_b > no_action; any losing strobe flags an error
          if (take_action_ocimem_a) begin
            addr_r        <= jdo[ADDR_W+1:2];
            inc_en_r      <= jdo[35];
            monitor_error <= take_action_ocimem_b | take_no_action_ocimem_a;
            if (jdo[34]) begin
              avm_read      <= 1'b1;
              monitor_ready <= 1'b0;
              state_r       <= ST_RD;
            end
          end else if (take_action_ocimem_b) begin
            avm_write     <= 1'b1;
            avm_writedata <= jdo[34:3];
            monitor_ready <= 1'b0;
            monitor_error <= take_no_action_ocimem_a;
            state_r       <= ST_WR;
          end else if (take_no_action_ocimem_a) begin
            avm_read      <= 1'b1;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
            state_r       <= ST_RD;
          end
        end
        ST_RD, ST_WR: begin
          if (!avm_waitrequest) begin
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            monitor_ready <= 1'b1;
            monitor_error <= monitor_error | any_strobe_s;
            tmo_cnt_r     <= '0;
            state_r       <= ST_IDLE;
            if (state_r == ST_RD) begin
              MonDReg <= avm_readdata;
            end
            if (inc_en_r) begin
              addr_r <= addr_r + ADDR_W'(1);
            end
          end else if (tmo_cnt_r == TMO_LAST) begin
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            monitor_ready <= 1'b1;
            monitor_error <= 1'b1;
            tmo_cnt_r     <= '0;
            state_r       <= ST_IDLE;
          end else begin
            tmo_cnt_r     <= tmo_cnt_r + TW'(1);
            monitor_error <= monitor_error | any_strobe_s;
          end
        end
        default: begin
          state_r       <= ST_IDLE;
          avm_read      <= 1'b0;
          avm_write     <= 1'b0;
          monitor_ready <= 1'b1;
          tmo_cnt_r     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpro_nios2_gen2_0_cpu_debug_mon_master.sv
// Directed bench for the debug monitor master: reset, reads, streamed wrap,
// stalled write, timeout, dropped strobes and strobe priority.
module tb_fpro_nios2_gen2_0_cpu_debug_mon_master;

  logic        clk;
  logic        reset_n;
  logic [37:0] jdo;
  logic        ta_a, tna_a, ta_b;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;
  logic [25:0] avm_address;
  logic        avm_read, avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  int checks = 0;
  int errors = 0;
  int both_cnt = 0;

  fpro_nios2_gen2_0_cpu_debug_mon_master #(.ADDR_W(24), .TIMEOUT(8)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (ta_a),
    .take_no_action_ocimem_a (tna_a),
    .take_action_ocimem_b    (ta_b),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .avm_address             (avm_address),
    .avm_read                (avm_read),
    .avm_write               (avm_write),
    .avm_writedata           (avm_writedata),
    .avm_byteenable          (avm_byteenable),
    .avm_readdata            (avm_readdata),
    .avm_waitrequest         (avm_waitrequest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (avm_read && avm_write) both_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [37:0] mk_a(input logic [23:0] addr, input logic inc, input logic rd);
    logic [37:0] j;
    j = 38'h0;
    j[25:2] = addr;
    j[35] = inc;
    j[34] = rd;
    return j;
  endfunction

  function automatic logic [37:0] mk_b(input logic [31:0] data);
    logic [37:0] j;
    j = 38'h0;
    j[34:3] = data;
    return j;
  endfunction

  initial begin
    // Reset with all strobes active
    reset_n = 1'b0; jdo = mk_a(24'h000055, 1'b1, 1'b1);
    ta_a = 1'b1; tna_a = 1'b1; ta_b = 1'b1;
    avm_readdata = 32'h0; avm_waitrequest = 1'b0;
    tick; tick; tick;
    chk("rst_ready", monitor_ready, 1'b1);
    chk("rst_error", monitor_error, 1'b0);
    chk("rst_read", avm_read, 1'b0);
    chk("rst_write", avm_write, 1'b0);
    chk("rst_mondreg", MonDReg, 32'h0);
    chk("byteenable", avm_byteenable, 4'hF);
    reset_n = 1'b1; ta_a = 1'b0; tna_a = 1'b0; ta_b = 1'b0;
    tick;

    // Address load + read at 0x10, no stall
    jdo = mk_a(24'h000010, 1'b0, 1'b1); ta_a = 1'b1; avm_readdata = 32'hDEADBEEF;
    tick;
    ta_a = 1'b0;
    chk("rd_req", avm_read, 1'b1);
    chk("rd_addr", avm_address, 26'h40);
    chk("rd_busy", monitor_ready, 1'b0);
    tick;
    chk("rd_drop", avm_read, 1'b0);
    chk("rd_data", MonDReg, 32'hDEADBEEF);
    chk("rd_ready", monitor_ready, 1'b1);

    // Load-only at 0xFFFFFF with increment, then three streamed reads
    jdo = mk_a(24'hFFFFFF, 1'b1, 1'b0); ta_a = 1'b1;
    tick;
    ta_a = 1'b0;
    chk("ld_noread", avm_read, 1'b0);
    chk("ld_ready", monitor_ready, 1'b1);
    tna_a = 1'b1; avm_readdata = 32'h11111111;
    tick;
    tna_a = 1'b0;
    chk("st0_addr", avm_address, 26'h3FFFFFC);
    tick;
    chk("st0_data", MonDReg, 32'h11111111);
    tna_a = 1'b1; avm_readdata = 32'h22222222;
    tick;
    tna_a = 1'b0;
    chk("st1_addr", avm_address, 26'h0);
    tick;
    chk("st1_data", MonDReg, 32'h22222222);
    tna_a = 1'b1; avm_readdata = 32'h33333333;
    tick;
    tna_a = 1'b0;
    chk("st2_addr", avm_address, 26'h4);
    tick;
    chk("st2_data", MonDReg, 32'h33333333);

    // Write 0x12345678 at word 2, stalled 5 cycles
    jdo = mk_b(32'h12345678); ta_b = 1'b1; avm_waitrequest = 1'b1;
    tick;
    ta_b = 1'b0; jdo = 38'h0;
    for (int i = 1; i <= 6; i++) begin
      chk("wr_held", avm_write, 1'b1);
      chk("wr_data", avm_writedata, 32'h12345678);
      chk("wr_addr", avm_address, 26'h8);
      if (i == 6) avm_waitrequest = 1'b0;
      if (i < 6) tick;
    end
    tick;
    chk("wr_drop", avm_write, 1'b0);
    chk("wr_ready", monitor_ready, 1'b1);
    chk("wr_error", monitor_error, 1'b0);

    // Read with waitrequest stuck high times out after 8 stall cycles
    tna_a = 1'b1; avm_waitrequest = 1'b1; avm_readdata = 32'h99999999;
    tick;
    tna_a = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      chk("tmo_held", avm_read, 1'b1);
      chk("tmo_busy", monitor_ready, 1'b0);
      tick;
    end
    chk("tmo_drop", avm_read, 1'b0);
    chk("tmo_error", monitor_error, 1'b1);
    chk("tmo_ready", monitor_ready, 1'b1);
    chk("tmo_mondreg", MonDReg, 32'h33333333);
    chk("tmo_addr", avm_address, 26'hC);

    // Strobe during RD is dropped and flags a sticky error
    tna_a = 1'b1;
    tick;
    tna_a = 1'b0;
    chk("drop_err_clr", monitor_error, 1'b0);
    jdo = mk_b(32'hA5A5A5A5); ta_b = 1'b1;
    tick;
    ta_b = 1'b0;
    chk("drop_error", monitor_error, 1'b1);
    chk("drop_nowrite", avm_write, 1'b0);
    chk("drop_read", avm_read, 1'b1);
    avm_waitrequest = 1'b0; avm_readdata = 32'hCAFEF00D;
    tick;
    chk("drop_done", avm_read, 1'b0);
    chk("drop_sticky", monitor_error, 1'b1);
    chk("drop_data", MonDReg, 32'hCAFEF00D);
    tick;
    chk("drop_nowr2", avm_write, 1'b0);

    // ocimem_a and ocimem_b together: read of the new address wins
    jdo = mk_a(24'h000020, 1'b0, 1'b1); ta_a = 1'b1; ta_b = 1'b1; avm_readdata = 32'h0BADF00D;
    tick;
    ta_a = 1'b0; ta_b = 1'b0;
    chk("pri_read", avm_read, 1'b1);
    chk("pri_nowrite", avm_write, 1'b0);
    chk("pri_addr", avm_address, 26'h80);
    chk("pri_error", monitor_error, 1'b1);
    tick;
    chk("pri_data", MonDReg, 32'h0BADF00D);
    chk("pri_ready", monitor_ready, 1'b1);
    chk("pri_nowr2", avm_write, 1'b0);

    // Next accepted command clears the error
    tna_a = 1'b1;
    tick;
    tna_a = 1'b0;
    chk("clr_error", monitor_error, 1'b0);
    chk("clr_addr", avm_address, 26'h80);
    tick;
    chk("both_never", both_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
